// File: rtl/dest_pipe_pkg.sv
// dest_pipe shared constants: specifier layout for the dual-issue pipe.
// Optional feature macro: DEST_REG0_FILTER_EN (drop r0 specifiers at entry).
package dest_pipe_pkg;

    localparam int SPEC_W    = 7;
    localparam int REG_W     = 6;
    localparam int VALID_BIT = 6;

    typedef logic [SPEC_W-1:0] spec_t;

    function automatic spec_t clr_valid(input spec_t s, input logic kill);
        clr_valid = {s[VALID_BIT] & ~kill, s[REG_W-1:0]};
    endfunction

endpackage

// File: rtl/dest_pipe_if.sv
// Decode/control side bundle for dest_pipe: R-stage inputs plus the
// E/M specifiers to the bypass comparators and the W write specifiers.
interface dest_pipe_if;
    import dest_pipe_pkg::*;

    spec_t ADestSpec_s1r;
    spec_t BDestSpec_s1r;
    logic  IssueValid_s1r;
    logic  Stall_s1;
    logic  SquashE_s1;
    spec_t ADest_s2e;
    spec_t BDest_s2e;
    spec_t ADest_s2m;
    spec_t BDest_s2m;
    spec_t AWrSpec_s1w;
    spec_t BWrSpec_s1w;

    modport master (
        output ADestSpec_s1r, BDestSpec_s1r, IssueValid_s1r,
        output Stall_s1, SquashE_s1,
        input  ADest_s2e, BDest_s2e, ADest_s2m, BDest_s2m,
        input  AWrSpec_s1w, BWrSpec_s1w
    );

    modport slave (
        input  ADestSpec_s1r, BDestSpec_s1r, IssueValid_s1r,
        input  Stall_s1, SquashE_s1,
        output ADest_s2e, BDest_s2e, ADest_s2m, BDest_s2m,
        output AWrSpec_s1w, BWrSpec_s1w
    );

endinterface

// File: rtl/dest_pipe_stage.sv
// dest_stage: one specifier register with hold, valid-kill and
// synchronous active-low reset.
module dest_stage
    import dest_pipe_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  hold,
    input  logic  clear_valid,
    input  spec_t d,
    output spec_t q
);

    spec_t src;

    always_comb begin
        src = hold ? q : d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= clr_valid(src, clear_valid);
        end
    end

endmodule

// File: rtl/dest_pipe.sv
// dest_pipe: A/B destination specifiers carried R->E->M->W with stall,
// squash and W-stage collision gating. Macro: DEST_REG0_FILTER_EN.
module dest_pipe
    import dest_pipe_pkg::*;
(
    input  logic        Phi1,
    input  logic        Reset_n_s1,
    dest_pipe_if.slave  dp
);

    spec_t r_q [2];
    spec_t e_q [2];
    spec_t m_q [2];
    spec_t w_q [2];
    spec_t r_in[2];
    logic  r_ok[2];
    logic  e_kill;
    logic  m_kill;
    logic  coll;

    assign r_in[0] = dp.ADestSpec_s1r;
    assign r_in[1] = dp.BDestSpec_s1r;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
`ifdef DEST_REG0_FILTER_EN
            r_ok[i] = (r_in[i][REG_W-1:0] != '0);
`else
            r_ok[i] = 1'b1;
`endif
            r_q[i] = {r_in[i][VALID_BIT] & dp.IssueValid_s1r & r_ok[i],
                      r_in[i][REG_W-1:0]};
        end
    end

    // Squash hits E where it sits: the held copy on stall, else the copy entering M.
    assign e_kill = dp.SquashE_s1 & dp.Stall_s1;
    assign m_kill = dp.SquashE_s1 & ~dp.Stall_s1;

    for (genvar s = 0; s < 2; s++) begin : g_slot
        dest_stage u_e (
            .clk         (Phi1),
            .rst_n       (Reset_n_s1),
            .hold        (dp.Stall_s1),
            .clear_valid (e_kill),
            .d           (r_q[s]),
            .q           (e_q[s])
        );

        dest_stage u_m (
            .clk         (Phi1),
            .rst_n       (Reset_n_s1),
            .hold        (dp.Stall_s1),
            .clear_valid (m_kill),
            .d           (e_q[s]),
            .q           (m_q[s])
        );

        dest_stage u_w (
            .clk         (Phi1),
            .rst_n       (Reset_n_s1),
            .hold        (1'b0),
            .clear_valid (dp.Stall_s1),
            .d           (m_q[s]),
            .q           (w_q[s])
        );
    end

    // B is younger, so on a same-register pair only B writes.
    assign coll = w_q[0][VALID_BIT] & w_q[1][VALID_BIT]
                & (w_q[0][REG_W-1:0] == w_q[1][REG_W-1:0]);

    assign dp.ADest_s2e   = e_q[0];
    assign dp.BDest_s2e   = e_q[1];
    assign dp.ADest_s2m   = m_q[0];
    assign dp.BDest_s2m   = m_q[1];
    assign dp.AWrSpec_s1w = clr_valid(w_q[0], coll);
    assign dp.BWrSpec_s1w = w_q[1];

endmodule

// File: tb/tb_dest_pipe.sv
// Directed bench for dest_pipe: flow, stall, squash, collision, r0, reset.
module tb_dest_pipe;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    dest_pipe_if dif ();

    dest_pipe u_dut (
        .Phi1       (clk),
        .Reset_n_s1 (rst_n),
        .dp         (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] got,
                       input logic [6:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dif.ADestSpec_s1r  = '0;
        dif.BDestSpec_s1r  = '0;
        dif.IssueValid_s1r = 1'b0;
        dif.Stall_s1       = 1'b0;
        dif.SquashE_s1     = 1'b0;
    endtask

    task automatic issue(input logic [6:0] a, input logic [6:0] b);
        dif.ADestSpec_s1r  = a;
        dif.BDestSpec_s1r  = b;
        dif.IssueValid_s1r = 1'b1;
    endtask

    task automatic chk_all0(input string tag);
        chk({tag, ".ae"}, dif.ADest_s2e, 7'h00);
        chk({tag, ".be"}, dif.BDest_s2e, 7'h00);
        chk({tag, ".am"}, dif.ADest_s2m, 7'h00);
        chk({tag, ".bm"}, dif.BDest_s2m, 7'h00);
        chk({tag, ".aw"}, dif.AWrSpec_s1w, 7'h00);
        chk({tag, ".bw"}, dif.BWrSpec_s1w, 7'h00);
    endtask

    task automatic drain();
        idle();
        repeat (4) tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        dif.ADestSpec_s1r  = 7'h55;
        dif.BDestSpec_s1r  = 7'h66;
        dif.IssueValid_s1r = 1'b1;
        dif.Stall_s1       = 1'b0;
        dif.SquashE_s1     = 1'b0;
        #1;
        tick();
        tick();
        chk_all0("rst");
        rst_n = 1'b1;
        idle();
        tick();

        // basic flow
        issue(7'h45, 7'h4A);
        tick();
        idle();
        chk("flow.ae", dif.ADest_s2e, 7'h45);
        chk("flow.be", dif.BDest_s2e, 7'h4A);
        tick();
        chk("flow.am", dif.ADest_s2m, 7'h45);
        chk("flow.bm", dif.BDest_s2m, 7'h4A);
        chk("flow.ae_idle", dif.ADest_s2e, 7'h00);
        tick();
        chk("flow.aw", dif.AWrSpec_s1w, 7'h45);
        chk("flow.bw", dif.BWrSpec_s1w, 7'h4A);
        tick();
        chk("flow.aw_end", dif.AWrSpec_s1w, 7'h00);
        drain();

        // stall two cycles
        issue(7'h43, 7'h00);
        tick();
        idle();
        chk("stl.ae0", dif.ADest_s2e, 7'h43);
        dif.Stall_s1 = 1'b1;
        tick();
        chk("stl.ae1", dif.ADest_s2e, 7'h43);
        chk("stl.aw1", dif.AWrSpec_s1w, 7'h00);
        tick();
        chk("stl.ae2", dif.ADest_s2e, 7'h43);
        chk("stl.aw2", dif.AWrSpec_s1w, 7'h00);
        dif.Stall_s1 = 1'b0;
        tick();
        chk("stl.am", dif.ADest_s2m, 7'h43);
        chk("stl.ae3", dif.ADest_s2e, 7'h00);
        chk("stl.aw3", dif.AWrSpec_s1w, 7'h00);
        tick();
        chk("stl.aw4", dif.AWrSpec_s1w, 7'h43);
        tick();
        chk("stl.aw5", dif.AWrSpec_s1w, 7'h00);
        drain();

        // squash without stall
        issue(7'h47, 7'h48);
        tick();
        idle();
        dif.SquashE_s1 = 1'b1;
        tick();
        dif.SquashE_s1 = 1'b0;
        chk("sq.am", dif.ADest_s2m, 7'h07);
        chk("sq.bm", dif.BDest_s2m, 7'h08);
        tick();
        chk("sq.aw", dif.AWrSpec_s1w, 7'h07);
        chk("sq.bw", dif.BWrSpec_s1w, 7'h08);
        drain();

        // squash with stall
        issue(7'h47, 7'h48);
        tick();
        idle();
        dif.SquashE_s1 = 1'b1;
        dif.Stall_s1   = 1'b1;
        tick();
        idle();
        chk("sqs.ae", dif.ADest_s2e, 7'h07);
        chk("sqs.be", dif.BDest_s2e, 7'h08);
        chk("sqs.am", dif.ADest_s2m, 7'h00);
        tick();
        chk("sqs.am2", dif.ADest_s2m, 7'h07);
        chk("sqs.bm2", dif.BDest_s2m, 7'h08);
        tick();
        chk("sqs.aw", dif.AWrSpec_s1w, 7'h07);
        chk("sqs.bw", dif.BWrSpec_s1w, 7'h08);
        drain();

        // same-bundle collision
        issue(7'h4C, 7'h4C);
        tick();
        idle();
        chk("col.ae", dif.ADest_s2e, 7'h4C);
        chk("col.be", dif.BDest_s2e, 7'h4C);
        tick();
        chk("col.am", dif.ADest_s2m, 7'h4C);
        chk("col.bm", dif.BDest_s2m, 7'h4C);
        tick();
        chk("col.aw", dif.AWrSpec_s1w, 7'h0C);
        chk("col.bw", dif.BWrSpec_s1w, 7'h4C);
        drain();

        // distinct registers at W both write
        issue(7'h4C, 7'h4D);
        tick();
        idle();
        tick();
        tick();
        chk("nocol.aw", dif.AWrSpec_s1w, 7'h4C);
        chk("nocol.bw", dif.BWrSpec_s1w, 7'h4D);
        drain();

        // r0 specifier
        issue(7'h40, 7'h00);
        tick();
        idle();
`ifdef DEST_REG0_FILTER_EN
        chk("r0.ae", dif.ADest_s2e, 7'h00);
        tick();
        tick();
        chk("r0.aw", dif.AWrSpec_s1w, 7'h00);
`else
        chk("r0.ae", dif.ADest_s2e, 7'h40);
        tick();
        tick();
        chk("r0.aw", dif.AWrSpec_s1w, 7'h40);
`endif
        drain();

        // reset mid-stream
        issue(7'h41, 7'h42);
        tick();
        issue(7'h43, 7'h44);
        tick();
        issue(7'h45, 7'h46);
        tick();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_all0("mrst");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst.aw", dif.AWrSpec_s1w, 7'h00);
            chk("mrst.bw", dif.BWrSpec_s1w, 7'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
